// File: rtl/cdb_arbiter_multi_pkg.sv
// Shared types and default constants for the multi-port CDB arbiter.
package cdb_arbiter_multi_pkg;

   localparam int CDB_TAG_W = 8;
   localparam int CDB_VAL_W = 32;

   // One result broadcast on the common data bus: ROB tag plus value.
   typedef struct packed {
      logic [CDB_TAG_W-1:0] tag;
      logic [CDB_VAL_W-1:0] value;
   } cdb_t;

   // Channel indices; a higher index means a higher fixed priority.
   localparam int CDB_CH_ALU = 0;
   localparam int CDB_CH_MUL = 1;
   localparam int CDB_CH_DIV = 2;
   localparam int CDB_CH_MEM = 3;
   localparam int CDB_CH_BR  = 4;

   localparam int CDB_Q_DEPTH      = 4;
   localparam int CDB_STARVE_LIMIT = 8;

endpackage

// File: rtl/cdb_arbiter_multi_chan_fifo.sv
// Single-channel result FIFO: count-based full/empty, flush, and a
// combinational head so the arbiter can steer it in the grant cycle.
module cdb_chan_fifo
   import cdb_arbiter_multi_pkg::*;
#(
   parameter int DEPTH = CDB_Q_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic flush_i,
   input  logic push_i,
   input  cdb_t data_i,
   input  logic pop_i,
   output cdb_t head_o,
   output logic empty_o,
   output logic full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   cdb_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   // A push into a full queue is dropped; flush discards everything in flight.
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign head_o  = mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/cdb_arbiter_multi.sv
// Multi-port CDB arbiter: per-channel FIFOs, fixed-priority grant with
// starvation promotion, up to NUM_CDB registered broadcasts per cycle.
// Optional macro CDB_ARB_BYPASS_EN lets an empty channel's incoming result
// compete for grant in the same cycle instead of passing through its FIFO.
module cdb_arbiter_multi
   import cdb_arbiter_multi_pkg::*;
#(
   parameter int NUM_CH       = CDB_CH_BR + 1,
   parameter int NUM_CDB      = 1,
   parameter int Q_DEPTH      = CDB_Q_DEPTH,
   parameter int STARVE_LIMIT = CDB_STARVE_LIMIT,
   localparam int SRC_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int AGE_W       = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic [NUM_CH-1:0]                fu_valid,
   input  cdb_t [NUM_CH-1:0]                fu_data,
   output logic [NUM_CH-1:0]                fu_ready,
   output logic [NUM_CDB-1:0]               cdb_valid,
   output cdb_t [NUM_CDB-1:0]               cdb_out,
   output logic [NUM_CDB-1:0][SRC_W-1:0]    cdb_src,
   output logic [NUM_CH-1:0]                starve_pending
);

   logic [NUM_CH-1:0]             fifo_empty;
   logic [NUM_CH-1:0]             fifo_full;
   cdb_t [NUM_CH-1:0]             fifo_head;
   logic [NUM_CH-1:0]             cand;
   cdb_t [NUM_CH-1:0]             cand_head;
   logic [NUM_CH-1:0]             grant;
   logic [NUM_CH-1:0]             push;
   logic [NUM_CH-1:0]             pop;
   logic                          found;

   logic [AGE_W-1:0]              age_q [NUM_CH];
   logic [AGE_W-1:0]              age_d [NUM_CH];
   logic [NUM_CH-1:0]             starve_q, starve_d;
   logic [NUM_CDB-1:0]            valid_q, valid_d;
   cdb_t [NUM_CDB-1:0]            out_q, out_d;
   logic [NUM_CDB-1:0][SRC_W-1:0] src_q, src_d;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      cdb_chan_fifo #(
         .DEPTH (Q_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .flush_i (flush),
         .push_i  (push[gi]),
         .data_i  (fu_data[gi]),
         .pop_i   (pop[gi]),
         .head_o  (fifo_head[gi]),
         .empty_o (fifo_empty[gi]),
         .full_o  (fifo_full[gi])
      );

      a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
         !(fu_valid[gi] && fifo_full[gi]))
         else $warning("cdb_arbiter_multi: result on full channel %0d dropped", gi);
   end

   // Backpressure reflects the registered count only.
   assign fu_ready       = ~fifo_full;
   assign cdb_valid      = valid_q;
   assign cdb_out        = out_q;
   assign cdb_src        = src_q;
   assign starve_pending = starve_q;

   // Which channels compete this cycle and what each would broadcast.
   always_comb begin
      cand      = '0;
      cand_head = '0;
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef CDB_ARB_BYPASS_EN
         cand[i]      = !fifo_empty[i] || fu_valid[i];
         cand_head[i] = fifo_empty[i] ? fu_data[i] : fifo_head[i];
`else
         cand[i]      = !fifo_empty[i];
         cand_head[i] = fifo_head[i];
`endif
      end
   end

   // Fill ports in order: promoted channels first, then plain fixed priority.
   always_comb begin
      grant   = '0;
      valid_d = '0;
      out_d   = '0;
      src_d   = '0;
      found   = 1'b0;
      for (int k = 0; k < NUM_CDB; k++) begin
         found = 1'b0;
         for (int p = 0; p < 2; p++) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
               if (!found && cand[i] && !grant[i] && (starve_q[i] == (p == 0))) begin
                  found      = 1'b1;
                  grant[i]   = 1'b1;
                  valid_d[k] = 1'b1;
                  src_d[k]   = SRC_W'(i);
                  out_d[k]   = cand_head[i];
               end
            end
         end
      end
   end

   // FIFO handshakes; a bypassed result skips its FIFO entirely.
   always_comb begin
      push = '0;
      pop  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef CDB_ARB_BYPASS_EN
         push[i] = fu_valid[i] && !(grant[i] && fifo_empty[i]);
`else
         push[i] = fu_valid[i];
`endif
         pop[i]  = grant[i] && !fifo_empty[i];
      end
   end

   // Age tracking: count ungranted waiting cycles, saturate at the limit.
   always_comb begin
      starve_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         age_d[i] = age_q[i];
         if (flush || grant[i] || fifo_empty[i]) begin
            age_d[i] = '0;
         end else if (age_q[i] != AGE_W'(STARVE_LIMIT)) begin
            age_d[i] = age_q[i] + 1'b1;
         end
         starve_d[i] = (age_d[i] == AGE_W'(STARVE_LIMIT));
      end
   end

   // Age and promotion registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) age_q[i] <= '0;
         starve_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) age_q[i] <= age_d[i];
         starve_q <= starve_d;
      end
   end

   // Registered CDB ports; flush discards the grants of its own cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         out_q   <= '0;
         src_q   <= '0;
      end else if (flush) begin
         valid_q <= '0;
         out_q   <= '0;
         src_q   <= '0;
      end else begin
         valid_q <= valid_d;
         out_q   <= out_d;
         src_q   <= src_d;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter_multi.sv
// Bench for cdb_arbiter_multi: two instances (one and two CDB ports) share
// stimulus; a queue-based reference model is compared every cycle, and
// directed literal expectations pin the main scenarios.
module tb_cdb_arbiter_multi;
   import cdb_arbiter_multi_pkg::*;

   localparam int NCH = 5;
   localparam int QD  = 4;
   localparam int LIM = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic [NCH-1:0]   fu_valid = '0;
   cdb_t [NCH-1:0]   fu_data = '0;

   logic [NCH-1:0]   rdy1, rdy2, sp1, sp2;
   logic [0:0]       v1;
   logic [1:0]       v2;
   cdb_t [0:0]       out1;
   cdb_t [1:0]       out2;
   logic [0:0][2:0]  src1;
   logic [1:0][2:0]  src2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cdb_arbiter_multi #(.NUM_CH(NCH), .NUM_CDB(1), .Q_DEPTH(QD), .STARVE_LIMIT(LIM)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .fu_valid(fu_valid), .fu_data(fu_data),
      .fu_ready(rdy1), .cdb_valid(v1), .cdb_out(out1), .cdb_src(src1), .starve_pending(sp1));

   cdb_arbiter_multi #(.NUM_CH(NCH), .NUM_CDB(2), .Q_DEPTH(QD), .STARVE_LIMIT(LIM)) u2 (
      .clk(clk), .rst(rst), .flush(flush), .fu_valid(fu_valid), .fu_data(fu_data),
      .fu_ready(rdy2), .cdb_valid(v2), .cdb_out(out2), .cdb_src(src2), .starve_pending(sp2));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic cdb_t mk(input logic [7:0] tag);
      cdb_t r;
      r.tag   = tag;
      r.value = {24'hC0DE00, tag};
      return r;
   endfunction

   // ---------------- reference model (index 0: one port, 1: two ports)
   cdb_t mq [10][$];
   int   age [2][NCH];
   bit   ev  [2][2];
   int   es  [2][2];
   cdb_t eo  [2][2];

   task automatic model_reset();
      for (int q = 0; q < 10; q++) mq[q].delete();
      for (int j = 0; j < 2; j++) begin
         for (int i = 0; i < NCH; i++) age[j][i] = 0;
         for (int k = 0; k < 2; k++) begin ev[j][k] = 0; es[j][k] = 0; eo[j][k] = '0; end
      end
   endtask

   task automatic model_step(input int j, input int ncdb);
      int order[$];
      bit emp [NCH];
      bit rdy [NCH];
      bit gr  [NCH];
      if (flush) begin
         for (int i = 0; i < NCH; i++) begin mq[j*NCH+i].delete(); age[j][i] = 0; end
         for (int k = 0; k < 2; k++) begin ev[j][k] = 0; es[j][k] = 0; eo[j][k] = '0; end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            emp[i] = (mq[j*NCH+i].size() == 0);
            rdy[i] = (mq[j*NCH+i].size() != QD);
            gr[i]  = 0;
         end
         // starving channels first, then everyone else, highest index first
         for (int pass = 0; pass < 2; pass++)
            for (int i = NCH - 1; i >= 0; i--)
               if (!emp[i] && ((age[j][i] == LIM) == (pass == 0)) && order.size() < ncdb) begin
                  order.push_back(i);
                  gr[i] = 1;
               end
         for (int k = 0; k < 2; k++) begin
            if (k < order.size()) begin
               ev[j][k] = 1; es[j][k] = order[k]; eo[j][k] = mq[j*NCH+order[k]][0];
            end else begin
               ev[j][k] = 0; es[j][k] = 0; eo[j][k] = '0;
            end
         end
         for (int i = 0; i < NCH; i++) begin
            if (gr[i] || emp[i]) age[j][i] = 0;
            else if (age[j][i] < LIM) age[j][i]++;
            if (gr[i]) void'(mq[j*NCH+i].pop_front());
            if (fu_valid[i] && rdy[i]) mq[j*NCH+i].push_back(fu_data[i]);
         end
      end
   endtask

   task automatic model_cmp(input int j, input int ncdb, input logic [4:0] rdy, input logic [4:0] sp,
                            input logic [1:0] v, input cdb_t o0, input cdb_t o1,
                            input logic [2:0] s0, input logic [2:0] s1);
      logic [4:0] er, esp;
      for (int i = 0; i < NCH; i++) begin
         er[i]  = (mq[j*NCH+i].size() != QD);
         esp[i] = (age[j][i] == LIM);
      end
      chk($sformatf("model%0d fu_ready", j), rdy, er);
      chk($sformatf("model%0d starve_pending", j), sp, esp);
      chk($sformatf("model%0d cdb_valid0", j), v[0], ev[j][0]);
      chk($sformatf("model%0d cdb_out0", j), o0, eo[j][0]);
      chk($sformatf("model%0d cdb_src0", j), s0, es[j][0]);
      if (ncdb > 1) begin
         chk($sformatf("model%0d cdb_valid1", j), v[1], ev[j][1]);
         chk($sformatf("model%0d cdb_out1", j), o1, eo[j][1]);
         chk($sformatf("model%0d cdb_src1", j), s1, es[j][1]);
      end
   endtask

   // Compare on the falling edge, then advance the model with the inputs
   // that the next rising edge will consume.
   always @(negedge clk) begin
      if (!rst) model_reset();
      model_cmp(0, 1, rdy1, sp1, {1'b0, v1[0]}, out1[0], '0, src1[0], 3'd0);
      model_cmp(1, 2, rdy2, sp2, v2, out2[0], out2[1], src2[0], src2[1]);
      if (rst) begin
         model_step(0, 1);
         model_step(1, 2);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      // reset then idle
      repeat (3) step();
      chk("reset valid", v1, 1'b0);
      chk("reset ready", rdy1, 5'h1f);
      chk("reset starve", sp1, 5'h00);
      rst = 1'b1;
      repeat (3) step();
      chk("idle valid", v1, 1'b0);
      chk("idle ready", rdy1, 5'h1f);

      // fixed priority with one port
      fu_data[0] = mk(8'h10); fu_data[2] = mk(8'h12); fu_data[4] = mk(8'h14);
      fu_valid = 5'b10101;
      step();
      fu_valid = '0;
      chk("prio enq edge valid", v1, 1'b0);
      step(); chk("prio src 1st", src1[0], 3'd4); chk("prio tag 1st", out1[0].tag, 8'h14);
      step(); chk("prio src 2nd", src1[0], 3'd2); chk("prio tag 2nd", out1[0].tag, 8'h12);
      step(); chk("prio src 3rd", src1[0], 3'd0); chk("prio tag 3rd", out1[0].tag, 8'h10);
      step(); chk("prio idle valid", v1, 1'b0);

      // backpressure on ch1 while ch4 keeps the single port busy
      for (int n = 0; n < 5; n++) begin
         fu_valid   = 5'b10010;
         fu_data[1] = mk(8'(8'h21 + n));
         fu_data[4] = mk(8'(8'h40 + n));
         step();
         if (n == 2) chk("bp ready after 3rd", rdy1[1], 1'b1);
         if (n == 3) chk("bp ready after 4th", rdy1[1], 1'b0);
      end
      fu_valid = '0;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (v1[0] && src1[0] == 3'd1) begin
            chk("bp drain tag", out1[0].tag, 8'(8'h21 + got));
            got++;
         end
      end
      chk("bp drain count", got, 4);
      chk("bp ready restored", rdy1, 5'h1f);

      // starvation of ch0 behind a continuously busy ch4
      fu_data[0] = mk(8'h50); fu_data[4] = mk(8'h60);
      fu_valid = 5'b10001;
      step();
      fu_valid = 5'b10000;
      for (int k = 1; k <= 8; k++) begin
         fu_data[4] = mk(8'(8'h60 + k));
         step();
         chk("starve busy src", src1[0], 3'd4);
         chk("starve pending", sp1[0], (k == 8));
      end
      fu_valid = '0;
      step();
      chk("starve grant src", src1[0], 3'd0);
      chk("starve grant tag", out1[0].tag, 8'h50);
      chk("starve cleared", sp1[0], 1'b0);
      repeat (4) step();

      // two ports: ch3 and ch1 together
      fu_data[3] = mk(8'h73); fu_data[1] = mk(8'h71);
      fu_valid = 5'b01010;
      step();
      fu_valid = '0;
      step();
      chk("mp valid", v2, 2'b11);
      chk("mp src0", src2[0], 3'd3);
      chk("mp src1", src2[1], 3'd1);
      chk("mp tag1", out2[1].tag, 8'h71);
      chk("mp single port src", src1[0], 3'd3);
      repeat (3) step();

      // flush collides with an enqueue on ch2
      fu_data[0] = mk(8'h80); fu_data[4] = mk(8'h90); fu_valid = 5'b10001;
      step();
      fu_data[0] = mk(8'h81); fu_data[4] = mk(8'h91);
      step();
      flush = 1'b1; fu_valid = 5'b00100; fu_data[2] = mk(8'hA2);
      step();
      flush = 1'b0; fu_valid = '0;
      chk("flush valid", v1, 1'b0);
      chk("flush valid 2p", v2, 2'b00);
      chk("flush ready", rdy1, 5'h1f);
      chk("flush starve", sp1, 5'h00);
      for (int c = 0; c < 6; c++) begin
         step();
         chk("flush no bcast", v1, 1'b0);
         chk("flush no bcast 2p", v2, 2'b00);
      end

      // asynchronous reset while a broadcast is on the bus
      fu_data[3] = mk(8'hB3); fu_valid = 5'b01000;
      step();
      fu_valid = '0;
      step();
      chk("arst pre valid", v1, 1'b1);
      chk("arst pre src", src1[0], 3'd3);
      #2 rst = 1'b0;
      #1;
      chk("arst valid", v1, 1'b0);
      chk("arst src", src1[0], 3'd0);
      chk("arst out", out1[0], '0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) step();
      chk("arst idle ready", rdy1, 5'h1f);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter_multi.md
Name: cdb_arbiter_multi

Overview:
Parametrised successor to the single-port CDB priority arbiter.
- Buffers results from NUM_CH functional units in per-channel FIFOs.
- Broadcasts up to NUM_CDB results per cycle on registered CDB ports.
- Grant order is fixed priority, with an anti-starvation promotion.
- Exposes per-channel backpressure to the FUs.
- Sits between the FU outputs and the ROB/reservation-station wakeup logic.

Parameters:
- NUM_CH, 5, number of FU channels. Channel NUM_CH-1 has the highest fixed priority (branch); channel 0 is lowest (ALU).
- NUM_CDB, 1, number of CDB broadcast ports per cycle. Legal range 1..NUM_CH.
- Q_DEPTH, 4, entries per channel FIFO. Power of two, >= 2.
- STARVE_LIMIT, 8, cycles a non-empty channel may go ungranted before promotion. Must be >= 1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous pipeline flush.
- fu_valid, input, NUM_CH, per-channel result valid.
- fu_data, input, NUM_CH x cdb_t, per-channel result payload.
- fu_ready, output, NUM_CH, per-channel FIFO has space.
- cdb_valid, output, NUM_CDB, CDB port carries a result this cycle.
- cdb_out, output, NUM_CDB x cdb_t, broadcast payloads.
- cdb_src, output, NUM_CDB x $clog2(NUM_CH), source channel of each port.
- starve_pending, output, NUM_CH, channel is currently promoted.

Behaviour:
- Reset (rst=0, async): all FIFOs empty; counts, pointers and age counters = 0; cdb_valid=0; cdb_out='0; cdb_src=0; starve_pending=0; fu_ready all 1.
- Enqueue: fu_valid[i] && fu_ready[i] at a rising edge writes the FIFO tail.
  - fu_valid while fu_ready=0 is an FU protocol violation. The data is dropped. An assertion fires in simulation.
- fu_ready[i] = (count[i] != Q_DEPTH). It is computed from the registered count only; a same-cycle dequeue does not free space.
- Grant (combinational each cycle over non-empty heads):
  - Promoted channels (starve_pending=1) are granted first, highest index first.
  - Remaining slots go to other non-empty channels by fixed priority, highest index first.
  - At most NUM_CDB grants; at most one per channel per cycle.
  - Grant k maps to CDB port k in grant order.
- Dequeue: a granted channel pops its head at the edge. Simultaneous enq and deq on the same channel is legal; count is unchanged.
  - A full FIFO that is dequeued still shows fu_ready=0 that cycle.
- Output:
  - cdb_out[k], cdb_src[k] and cdb_valid[k] are registered from the grant at the same edge as the pop.
  - Latency: enq at edge t, broadcast visible after edge t+1 if granted at first opportunity.
  - Unused ports: cdb_valid=0, payload '0.
- Age counters:
  - age[i] increments, saturating at STARVE_LIMIT, when channel i is non-empty and not granted.
  - age[i] clears on a grant or when channel i is empty.
  - starve_pending[i] = (age[i] == STARVE_LIMIT), registered.
- Pointers: wrap modulo Q_DEPTH. Count width is $clog2(Q_DEPTH)+1.
- Flush (sync):
  - At the next edge, all FIFOs, ages and starve_pending clear, and cdb_valid=0.
  - Flush wins over a simultaneous enqueue; the enqueued data is discarded.
  - Grants computed in the flush cycle are discarded.
- Async reset mid-operation clears everything immediately, independent of clk.

Optional Feature:
- Macro: CDB_ARB_BYPASS_EN.
- Defined:
  - A channel whose FIFO is empty and has fu_valid=1 competes for grant in the same cycle, using fu_data as its head.
  - If granted, the data goes directly to the registered CDB output and is not written to the FIFO.
  - If not granted, it is enqueued normally.
  - Latency: fu_valid at cycle t, broadcast visible after edge t+1, i.e. zero buffering cycles.
- Undefined: all data passes through the FIFO; no combinational path from fu_valid/fu_data to the grant logic.

Decomposition:
- Shared package (types):
  - cdb_t.
  - Channel index localparams: CDB_CH_ALU=0, MUL=1, DIV=2, MEM=3, BR=4.
  - Default depth constants: CDB_Q_DEPTH, CDB_STARVE_LIMIT.
- Sub-module cdb_chan_fifo: single-channel FIFO with count, push/pop, flush and full/empty. Instantiated NUM_CH times via generate.
- Grant/age logic stays in the top module.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release with no fu_valid -> cdb_valid=0, fu_ready=5'b11111, starve_pending=0 throughout.
- Priority, NUM_CDB=1: at the same edge enqueue ch0 (tag 0x10), ch2 (0x12), ch4 (0x14) -> over the next 3 cycles cdb_src = 4, 2, 0 with the matching payloads; then cdb_valid=0.
- Full/backpressure, Q_DEPTH=4: push 4 entries into ch1 while ch4 is kept busy -> fu_ready[1]=0 after the 4th push; a 5th fu_valid is dropped and the assertion fires; drain yields exactly 4 entries in order.
- Starvation, STARVE_LIMIT=8: keep ch4 continuously non-empty with ch0 holding one entry -> ch0 ungranted for 8 cycles, starve_pending[0]=1, granted on the next cycle, then age resets.
- Multi-port, NUM_CDB=2: ch3 and ch1 non-empty in the same cycle -> cdb_valid=2'b11, cdb_src[0]=3, cdb_src[1]=1 at the next edge.
- Flush collision: assert flush in the same cycle as fu_valid on ch2 with 2 entries queued on ch0 -> after the edge all counts are 0, cdb_valid=0, and no ch2 data is ever broadcast.
